// File: rtl/crypto_pkg.sv
// Shared types and constants for the round sequencer and its combinational round core.
package crypto_pkg;
   typedef enum logic [1:0] {IDLE, ROUND, DONE} crypto_seq_state_t;

   localparam int   CRYPTO_DATA_W = 32;
   localparam int   CRYPTO_KEY_W  = 32;
   localparam int   CRYPTO_CNT_W  = 2;
   localparam logic CRYPTO_ENC    = 1'b0;
   localparam logic CRYPTO_DEC    = 1'b1;
endpackage

// File: rtl/cryptography_module.sv
// Combinational round core: one invertible round selected by cnt; sel=1 applies the exact inverse.
// Pure combinational, no backpressure; encrypt rounds 0..3 undone by decrypt rounds 3..0.
module Cryptography_Module (
   input  logic [31:0] data_in,
   input  logic [31:0] key,
   input  logic [1:0]  cnt,
   input  logic        sel,
   output logic [31:0] result
);
   localparam logic [31:0] RC = 32'h9e3779b9;

   logic [4:0]  sh;
   logic [5:0]  kb;
   logic [31:0] rk;
   logic [31:0] x;
   logic [31:0] y;

   always_comb begin
      sh     = 5'd3 + 5'd5 * {3'd0, cnt};
      kb     = {1'b0, cnt, 3'b000};
      // round key is the key rotated left by a whole number of bytes
      rk     = (key << kb) | (key >> (6'd32 - kb));
      x      = '0;
      y      = '0;
      result = '0;
      if (sel == 1'b0) begin
         x      = data_in ^ rk;
         y      = (x << sh) | (x >> (6'd32 - {1'b0, sh}));
         result = y + RC;
      end else begin
         y      = data_in - RC;
         x      = (y >> sh) | (y << (6'd32 - {1'b0, sh}));
         result = x ^ rk;
      end
   end
endmodule

// File: rtl/crypto_round_sequencer.sv
// Drives an external round core NUM_ROUNDS cycles per block; out_valid NUM_ROUNDS cycles after accept,
// result held until out_ready, no new block accepted meanwhile. Optional abort port: CRYPTO_ABORT_EN.
module crypto_round_sequencer
   import crypto_pkg::*;
#(
   parameter int DATA_W     = CRYPTO_DATA_W,
   parameter int KEY_W      = CRYPTO_KEY_W,
   parameter int CNT_W      = CRYPTO_CNT_W,
   parameter int NUM_ROUNDS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEY_W-1:0]  in_key,
   input  logic              in_sel,
   output logic [DATA_W-1:0] core_din,
   output logic [KEY_W-1:0]  core_key,
   output logic [CNT_W-1:0]  core_cnt,
   output logic              core_sel,
   input  logic [DATA_W-1:0] core_result,
`ifdef CRYPTO_ABORT_EN
   input  logic              abort,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << CNT_W)) begin : g_bad_rounds
      $error("NUM_ROUNDS must be in 1..2**CNT_W");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

   crypto_seq_state_t state, state_nxt;
   logic [DATA_W-1:0] work, work_nxt;
   logic [DATA_W-1:0] out_q, out_nxt;
   logic [KEY_W-1:0]  key_q, key_nxt;
   logic              sel_q, sel_nxt;
   logic [CNT_W-1:0]  ctr, ctr_nxt;
   logic              last_round;
   logic              abort_req;

`ifdef CRYPTO_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign last_round = (sel_q == CRYPTO_DEC) ? (ctr == '0) : (ctr == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         work  <= '0;
         out_q <= '0;
         key_q <= '0;
         sel_q <= 1'b0;
         ctr   <= '0;
      end else begin
         state <= state_nxt;
         work  <= work_nxt;
         out_q <= out_nxt;
         key_q <= key_nxt;
         sel_q <= sel_nxt;
         ctr   <= ctr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      work_nxt  = work;
      out_nxt   = out_q;
      key_nxt   = key_q;
      sel_nxt   = sel_q;
      ctr_nxt   = ctr;
      case (state)
         IDLE: begin
            if (in_valid) begin
               work_nxt  = in_data;
               key_nxt   = in_key;
               sel_nxt   = in_sel;
               ctr_nxt   = (in_sel == CRYPTO_DEC) ? LAST : '0;
               state_nxt = ROUND;
            end
         end
         ROUND: begin
            work_nxt = core_result;
            // terminal check comes first so the counter never wraps
            if (last_round) begin
               out_nxt   = core_result;
               state_nxt = DONE;
            end else if (sel_q == CRYPTO_DEC) begin
               ctr_nxt = ctr - CNT_W'(1);
            end else begin
               ctr_nxt = ctr + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort_req && state != IDLE) begin
         state_nxt = IDLE;
         work_nxt  = '0;
         out_nxt   = '0;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == ROUND);
   assign out_data  = out_q;
   assign core_din  = work;
   assign core_key  = key_q;
   assign core_sel  = sel_q;
   assign core_cnt  = ctr;
endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Bench: sequencer plus round core, checked against an arithmetic model of the round function.
module tb_crypto_round_sequencer;
   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [31:0] in_key = '0;
   logic        in_sel = 1'b0;
   logic [31:0] core_din;
   logic [31:0] core_key;
   logic [1:0]  core_cnt;
   logic        core_sel;
   logic [31:0] core_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        busy;
`ifdef CRYPTO_ABORT_EN
   logic        abort = 1'b0;
`endif

   int total = 0;
   int passed = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   crypto_round_sequencer #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key), .in_sel(in_sel),
      .core_din(core_din), .core_key(core_key), .core_cnt(core_cnt), .core_sel(core_sel),
      .core_result(core_result),
`ifdef CRYPTO_ABORT_EN
      .abort(abort),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   Cryptography_Module core (
      .data_in(core_din), .key(core_key), .cnt(core_cnt), .sel(core_sel), .result(core_result)
   );

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction

   // round r: xor with key rotated by 8r bits, rotate by 5r+3, add the golden-ratio constant
   function automatic logic [31:0] model_round(input logic [31:0] w, input logic [31:0] k,
                                               input int r, input logic dec);
      logic [31:0] rk;
      int          s;
      rk = rotl(k, 8 * r);
      s  = 5 * r + 3;
      if (!dec) return rotl(w ^ rk, s) + 32'h9e3779b9;
      return rotl(w - 32'h9e3779b9, 32 - s) ^ rk;
   endfunction

   function automatic logic [31:0] model_block(input logic [31:0] d, input logic [31:0] k,
                                               input logic dec);
      logic [31:0] w;
      w = d;
      for (int r = 0; r < NR; r++) w = model_round(w, k, dec ? NR - 1 - r : r, dec);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
   endtask

   task automatic send(input logic [31:0] d, input logic [31:0] k, input logic s);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = d; in_key = k; in_sel = s;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_rounds(input logic [31:0] d, input logic [31:0] k, input logic s,
                               output logic [31:0] res);
      logic [31:0] w;
      int          c;
      w = d;
      for (int r = 0; r < NR; r++) begin
         c = s ? NR - 1 - r : r;
         chk("rnd_cnt", 32'(core_cnt), 32'(c));
         chk("rnd_din", core_din, w);
         chk("rnd_key", core_key, k);
         chk("rnd_flags", {28'd0, busy, in_ready, out_valid, core_sel}, {28'd0, 3'b100, s});
         w = model_round(w, k, c, s);
         @(negedge clk);
      end
      chk("done_flags", {29'd0, busy, in_ready, out_valid}, 32'b001);
      chk("done_data", out_data, model_block(d, k, s));
      res = out_data;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_flags", {29'd0, busy, in_ready, out_valid}, 32'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] enc, res, d, k, prev_out;
      logic [31:0] bd[3], bk[3];
      logic        bs[3];
      int          t_prev;
      logic        s;

      // reset values
      #2;
      chk("rst_flags", {29'd0, busy, in_ready, out_valid}, 32'b010);
      chk("rst_out", out_data, 32'd0);
      chk("rst_core", {core_cnt, core_sel, core_din[28:0]}, 32'd0);
      chk("rst_key", core_key, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // encrypt the reference vector
      send(32'hdeadbeef, 32'hc0ffeeee, 1'b0);
      check_rounds(32'hdeadbeef, 32'hc0ffeeee, 1'b0, enc);
      drain();

      // decrypt vector, then round trip
      send(32'h1c025000, 32'hc0ffeeee, 1'b1);
      check_rounds(32'h1c025000, 32'hc0ffeeee, 1'b1, res);
      drain();
      send(enc, 32'hc0ffeeee, 1'b1);
      check_rounds(enc, 32'hc0ffeeee, 1'b1, res);
      chk("round_trip", res, 32'hdeadbeef);
      drain();

      // backpressure: result held, a waiting block is ignored until the pulse
      d = $urandom; k = $urandom;
      send(d, k, 1'b0);
      check_rounds(d, k, 1'b0, prev_out);
      in_valid = 1'b1; in_data = ~d; in_key = k; in_sel = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_flags", {29'd0, busy, in_ready, out_valid}, 32'b001);
         chk("bp_data", out_data, prev_out);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle", {29'd0, busy, in_ready, out_valid}, 32'b010);
      @(negedge clk);
      in_valid = 1'b0;
      check_rounds(~d, k, 1'b1, res);
      drain();

      // asynchronous reset during round 2
      d = $urandom; k = $urandom;
      send(d, k, 1'b0);
      @(negedge clk); @(negedge clk);
      chk("mid_cnt", 32'(core_cnt), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_flags", {29'd0, busy, in_ready, out_valid}, 32'b010);
      chk("arst_core", {core_cnt, core_sel, core_din[28:0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(d, k, 1'b0);
      check_rounds(d, k, 1'b0, res);
      drain();

      // back-to-back: three blocks, in_valid held, out_ready held
      for (int i = 0; i < 3; i++) begin
         bd[i] = $urandom; bk[i] = $urandom; bs[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = bd[0]; in_key = bk[0]; in_sel = bs[0];
      t_prev = 0;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         chk("b2b_busy", 32'(busy), 32'd1);
         if (b < 2) begin
            in_data = bd[b + 1]; in_key = bk[b + 1]; in_sel = bs[b + 1];
         end else begin
            in_valid = 1'b0;
         end
         repeat (NR) @(negedge clk);
         chk("b2b_valid", 32'(out_valid), 32'd1);
         chk("b2b_data", out_data, model_block(bd[b], bk[b], bs[b]));
         if (b > 0) chk("b2b_gap", 32'(cyc - t_prev), 32'd6);
         t_prev = cyc;
         @(negedge clk);
         chk("b2b_idle", 32'(in_ready), 32'd1);
      end
      out_ready = 1'b0;

      // randomized blocks with random downstream stall
      for (int i = 0; i < 6; i++) begin
         d = $urandom; k = $urandom; s = 1'($urandom_range(0, 1));
         send(d, k, s);
         check_rounds(d, k, s, res);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("rnd_hold", out_data, res);
         end
         drain();
      end

`ifdef CRYPTO_ABORT_EN
      // abort during round 1, then a clean block
      d = $urandom; k = $urandom;
      send(d, k, 1'b0);
      @(negedge clk);
      chk("ab_cnt", 32'(core_cnt), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_flags", {29'd0, busy, in_ready, out_valid}, 32'b010);
      chk("ab_clear", core_din | out_data, 32'd0);
      send(d, k, 1'b0);
      check_rounds(d, k, 1'b0, res);
      drain();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
